lamp_phase_sequencer: RTL
=========================

Name: lamp_phase_sequencer

Overview:
- Controls the lamp panel. It runs a fixed cycle of three phases: WHITE, then SUN, then YELLOW, then back to WHITE.
- Each phase has a 2-digit BCD countdown with a programmable length. A debounced key starts, pauses and resumes the sequence.
- It drives the BCD display value, the LED pattern, the dp status nibble and a one-cycle phase_done pulse.
- It sits between the raw board inputs (key, switches) and the display/LED outputs.

Parameters:
- TICK_DIV, 5000000: clk cycles per countdown tick in run mode (10 Hz at 50 MHz).
- DEMO_DIV, 500000: clk cycles per countdown tick when sw_demo=1.
- DEBOUNCE, 200000: cycles the synchronized key must stay stable before it is accepted.
- WHITE_T, 8'h30: BCD load value for WHITE. Must be valid BCD and nonzero.
- SUN_T, 8'h20: BCD load value for SUN. Must be valid BCD and nonzero.
- YELLOW_T, 8'h05: BCD load value for YELLOW. Must be valid BCD and nonzero.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-low.
- key  in  1  raw start/pause button, active-high, asynchronous to clk.
- sw_power  in  1  master enable; 0 forces OFF.
- sw_demo  in  1  1 selects DEMO_DIV, 0 selects TICK_DIV.
- num  out  8  BCD countdown {tens, units}.
- phase  out  2  0=WHITE, 1=SUN, 2=YELLOW; 3 is never driven.
- led  out  4  lamp pattern.
- dp  out  4  one-hot state indicator.
- phase_done  out  1  one-cycle pulse on phase expiry.

Behaviour:
Clocking and reset
- One clock. Reset is synchronous and active-low, sampled on posedge clk: rst=0 acts at the next posedge, not asynchronously.
- All outputs are registered.
- Reset values: state=OFF, num=8'h00, phase=0, led=0, dp=0, phase_done=0. The prescaler, debounce counter and synchronizer flops are all cleared.

Key path
- 2-flop synchronizer, then debounce. The debounced level updates only after DEBOUNCE consecutive identical synchronized samples.
- press = one-cycle pulse on a rising edge of the debounced level. Releasing the key produces nothing.

States
- OFF: num=00, led=0000, dp=0000. Leaves to READY when sw_power=1.
- READY: on entry phase=WHITE, num=WHITE_T, prescaler=0. led=1100, dp=0001. press -> RUN.
- RUN: prescaler counts 0..DIV-1. tick is asserted in the cycle the prescaler equals DIV-1; the prescaler then wraps to 0.
  - On tick with num!=00: BCD decrement. Units 0 becomes 9 and tens decrements. There is no binary wrap and no invalid BCD.
  - On tick with num==00: go to EXPIRE.
  - press -> PAUSE.
  - led: WHITE=1100, SUN=0110, YELLOW=0011. dp=0010.
- PAUSE: num and prescaler hold. led=0000, dp=0100. press -> RUN; the prescaler resumes from its held value.
- EXPIRE: lasts exactly one cycle.
  - phase_done=1, dp=1000, led=0000.
  - phase advances WHITE->SUN->YELLOW->WHITE and num loads the new phase's T. The prescaler stays at 0.
  - Next state is RUN unconditionally. A press during EXPIRE is ignored.

Boundary cases
- A phase lasts (T+1) ticks: the display shows T down to 00, and the tick after 00 triggers expiry.
- press and tick in the same cycle in RUN: press wins, the tick is discarded, num is unchanged, state goes to PAUSE.
- sw_power=0 in any state: OFF at the next posedge. All outputs go to OFF values; prescaler and phase clear; the debounce state is kept.
- A sw_demo change in any state clears the prescaler the same cycle. The new divider applies from 0 and num is untouched.
- rst=0 mid-operation: reset values at the next posedge, regardless of sw_power.
- Prescaler width is clog2(max(TICK_DIV, DEMO_DIV)).

Test Plan:
Common bench parameters: TICK_DIV=4, DEMO_DIV=2, DEBOUNCE=3, WHITE_T=8'h12, SUN_T=8'h03, YELLOW_T=8'h02.
1. Reset, then power on: rst=0 for 2 cycles, sw_power=1 -> OFF, then READY one cycle later with num=8'h12, phase=0, led=1100, dp=0001.
2. Debounce: key glitches high for 2 cycles -> no press and state stays READY. key held high for 6 cycles -> exactly one press and state becomes RUN, with dp=0010.
3. Countdown and phase advance (sw_demo=0): from num=12, the 12th tick shows 8'h00, covering both 10->09 and 09->08. The 13th tick produces EXPIRE with phase_done=1 for one cycle, then phase=1, num=8'h03, led=0110. The full cycle runs WHITE->SUN->YELLOW->WHITE.
4. Pause and resume: press with 2 cycles left before a tick -> PAUSE, num frozen, led=0000. Wait 20 cycles, press -> RUN; the next tick arrives 2 cycles later.
5. Press coincident with tick: press lands in the prescaler=3 cycle -> state PAUSE and num unchanged.
6. Power drop and demo switch: sw_demo toggles mid-count -> prescaler clears and the next tick comes 2 cycles later. sw_power=0 while in RUN -> OFF at the next edge with num=00, led=0, dp=0. Restoring power -> READY with WHITE_T.

Source files
------------

// File: rtl/lamp_phase_sequencer.sv
// -----------------------------------------------------------------------------
// lamp_phase_sequencer
//
// Purpose:
//   Drives the lamp panel through a repeating WHITE -> SUN -> YELLOW cycle.
//   Each phase counts down a 2-digit BCD value from its programmed length.
//   A debounced key starts, pauses and resumes the sequence.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   key        in   raw start/pause button, active-high, asynchronous to clk
//   sw_power   in   master enable; 0 forces OFF
//   sw_demo    in   1 selects DEMO_DIV, 0 selects TICK_DIV as the tick divider
//   num        out  BCD countdown {tens, units}
//   phase      out  0=WHITE, 1=SUN, 2=YELLOW
//   led        out  lamp pattern
//   dp         out  one-hot state indicator
//   phase_done out  one-cycle pulse when a phase expires
// -----------------------------------------------------------------------------
module lamp_phase_sequencer #(
    parameter int         TICK_DIV = 5000000,
    parameter int         DEMO_DIV = 500000,
    parameter int         DEBOUNCE = 200000,
    parameter logic [7:0] WHITE_T  = 8'h30,
    parameter logic [7:0] SUN_T    = 8'h20,
    parameter logic [7:0] YELLOW_T = 8'h05
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       sw_power,
    input  logic       sw_demo,
    output logic [7:0] num,
    output logic [1:0] phase,
    output logic [3:0] led,
    output logic [3:0] dp,
    output logic       phase_done
);

    localparam int DIV_MAX = (TICK_DIV > DEMO_DIV) ? TICK_DIV : DEMO_DIV;
    localparam int PW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int DBW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  DEMO_LAST = PW'(DEMO_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE - 1);

    localparam logic [1:0] PH_WHITE  = 2'd0;
    localparam logic [1:0] PH_SUN    = 2'd1;
    localparam logic [1:0] PH_YELLOW = 2'd2;

    typedef enum logic [2:0] {
        S_OFF,
        S_READY,
        S_RUN,
        S_PAUSE,
        S_EXPIRE
    } state_t;

    // BCD decrement: units borrow from tens; callers never pass 8'h00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [1:0] phase_next(input logic [1:0] p);
        case (p)
            PH_WHITE: return PH_SUN;
            PH_SUN:   return PH_YELLOW;
            default:  return PH_WHITE;
        endcase
    endfunction

    function automatic logic [7:0] phase_len(input logic [1:0] p);
        case (p)
            PH_WHITE: return WHITE_T;
            PH_SUN:   return SUN_T;
            default:  return YELLOW_T;
        endcase
    endfunction

    function automatic logic [3:0] phase_led(input logic [1:0] p);
        case (p)
            PH_WHITE: return 4'b1100;
            PH_SUN:   return 4'b0110;
            default:  return 4'b0011;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [7:0]     num_q, num_d;
    logic [1:0]     phase_q, phase_d;
    logic [3:0]     led_q, led_d;
    logic [3:0]     dp_q, dp_d;
    logic           phase_done_q, phase_done_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic           key_s1_q, key_s1_d;
    logic           key_s2_q, key_s2_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           db_lvl_q, db_lvl_d;
    logic           db_prev_q, db_prev_d;
    logic           demo_q, demo_d;

    logic           press;
    logic           demo_chg;
    logic           tick;
    logic [PW-1:0]  div_last;

    always_comb begin
        // Key synchronizer and debounce: the accepted level only follows the
        // synchronized key after DEBOUNCE consecutive differing samples.
        key_s1_d  = key;
        key_s2_d  = key_s1_q;
        db_cnt_d  = '0;
        db_lvl_d  = db_lvl_q;
        if (key_s2_q != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_lvl_d = key_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        db_prev_d = db_lvl_q;
        press     = db_lvl_q & ~db_prev_q;

        // A divider change restarts the prescaler and swallows any pending tick.
        demo_d   = sw_demo;
        demo_chg = (sw_demo != demo_q);
        div_last = sw_demo ? DEMO_LAST : TICK_LAST;
        tick     = (state_q == S_RUN) && (presc_q == div_last) && !demo_chg;

        state_d = state_q;
        num_d   = num_q;
        phase_d = phase_q;
        presc_d = presc_q;

        case (state_q)
            S_OFF: begin
                presc_d = '0;
                if (sw_power) begin
                    state_d = S_READY;
                    phase_d = PH_WHITE;
                    num_d   = WHITE_T;
                end
            end
            S_READY: begin
                presc_d = '0;
                if (press) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Press has priority: a coincident tick is dropped and the
                // prescaler freezes where it is.
                if (press) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    presc_d = '0;
                    if (num_q == 8'h00) begin
                        state_d = S_EXPIRE;
                        phase_d = phase_next(phase_q);
                        num_d   = phase_len(phase_next(phase_q));
                    end else begin
                        num_d = bcd_dec(num_q);
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (press) begin
                    state_d = S_RUN;
                end
            end
            S_EXPIRE: begin
                state_d = S_RUN;
                presc_d = '0;
            end
            default: begin
                state_d = S_OFF;
                num_d   = 8'h00;
                phase_d = PH_WHITE;
                presc_d = '0;
            end
        endcase

        if (demo_chg) begin
            presc_d = '0;
        end

        if (!sw_power) begin
            state_d = S_OFF;
            num_d   = 8'h00;
            phase_d = PH_WHITE;
            presc_d = '0;
        end

        // Outputs are registered from the next-state values so they line up
        // with the state they describe.
        phase_done_d = (state_d == S_EXPIRE);
        case (state_d)
            S_READY: begin
                led_d = 4'b1100;
                dp_d  = 4'b0001;
            end
            S_RUN: begin
                led_d = phase_led(phase_d);
                dp_d  = 4'b0010;
            end
            S_PAUSE: begin
                led_d = 4'b0000;
                dp_d  = 4'b0100;
            end
            S_EXPIRE: begin
                led_d = 4'b0000;
                dp_d  = 4'b1000;
            end
            default: begin
                led_d = 4'b0000;
                dp_d  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_OFF;
            num_q        <= 8'h00;
            phase_q      <= PH_WHITE;
            led_q        <= 4'b0000;
            dp_q         <= 4'b0000;
            phase_done_q <= 1'b0;
            presc_q      <= '0;
            key_s1_q     <= 1'b0;
            key_s2_q     <= 1'b0;
            db_cnt_q     <= '0;
            db_lvl_q     <= 1'b0;
            db_prev_q    <= 1'b0;
            demo_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            phase_q      <= phase_d;
            led_q        <= led_d;
            dp_q         <= dp_d;
            phase_done_q <= phase_done_d;
            presc_q      <= presc_d;
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            db_cnt_q     <= db_cnt_d;
            db_lvl_q     <= db_lvl_d;
            db_prev_q    <= db_prev_d;
            demo_q       <= demo_d;
        end
    end

    assign num        = num_q;
    assign phase      = phase_q;
    assign led        = led_q;
    assign dp         = dp_q;
    assign phase_done = phase_done_q;

endmodule
